// File: rtl/julia_pkg.sv
// Shared types and defaults for the Julia coordinate generator.
package julia_pkg;

  localparam int unsigned COORD_W       = 27;
  localparam int unsigned FRAC_BITS     = 23;
  localparam int unsigned H_RES_DEFAULT = 640;
  localparam int unsigned V_RES_DEFAULT = 480;
  localparam int unsigned IDX_W_DEFAULT = 10;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } gen_state_t;

endpackage

// File: rtl/julia_axis_stepper.sv
// One raster axis: index counter plus wrapping coordinate accumulator with
// base/step snapshot taken on load.
module julia_axis_stepper #(
  parameter int unsigned W       = 27,
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned MAX_IDX = 639
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step_en,
  input  logic             wrap,
  input  logic [W-1:0]     base,
  input  logic [W-1:0]     step,
  output logic [IDX_W-1:0] idx,
  output logic [W-1:0]     coord,
  output logic             at_max,
  output logic             at_max_nxt_c
);

  logic [W-1:0]     base_sh;
  logic [W-1:0]     step_sh;
  logic [IDX_W-1:0] idx_nxt;
  logic [W-1:0]     coord_nxt;

  // Repeated addition of the snapshotted step is exact modulo 2^W.
  always_comb begin
    idx_nxt   = idx;
    coord_nxt = coord;
    if (load) begin
      idx_nxt   = '0;
      coord_nxt = base;
    end else if (step_en) begin
      if (wrap) begin
        idx_nxt   = '0;
        coord_nxt = base_sh;
      end else begin
        idx_nxt   = idx + IDX_W'(1);
        coord_nxt = coord + step_sh;
      end
    end
    at_max_nxt_c = (idx_nxt == IDX_W'(MAX_IDX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_sh <= '0;
      step_sh <= '0;
      idx     <= '0;
      coord   <= '0;
      at_max  <= 1'b0;
    end else begin
      if (load) begin
        base_sh <= base;
        step_sh <= step;
      end
      idx    <= idx_nxt;
      coord  <= coord_nxt;
      at_max <= at_max_nxt_c;
    end
  end

endmodule

// File: rtl/julia_coord_gen.sv
// Raster generator of per-pixel complex coordinates for the Julia iterators.
// JULIA_CONTINUOUS_FRAME_EN: frames restart back-to-back after the first start.
module julia_coord_gen #(
  parameter int unsigned COORD_W = julia_pkg::COORD_W,
  parameter int unsigned H_RES   = julia_pkg::H_RES_DEFAULT,
  parameter int unsigned V_RES   = julia_pkg::V_RES_DEFAULT,
  parameter int unsigned IDX_W   = julia_pkg::IDX_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x_0,
  input  logic [COORD_W-1:0] x_step,
  input  logic [COORD_W-1:0] y_0,
  input  logic [COORD_W-1:0] y_step,
  input  logic               start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] c_re,
  output logic [COORD_W-1:0] c_im,
  output logic [IDX_W-1:0]   pix_col,
  output logic [IDX_W-1:0]   pix_row,
  output logic               last,
  output logic               busy,
  output logic               frame_done
);

  import julia_pkg::*;

  gen_state_t state;
  gen_state_t state_nxt;

  logic load;
  logic xfer;
  logic frame_end;
  logic x_step_en;
  logic y_step_en;
  logic x_at_max;
  logic y_at_max;
  logic x_max_nxt;
  logic y_max_nxt;

  julia_axis_stepper #(
    .W       (COORD_W),
    .IDX_W   (IDX_W),
    .MAX_IDX (H_RES - 1)
  ) u_x_axis (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .step_en      (x_step_en),
    .wrap         (x_at_max),
    .base         (x_0),
    .step         (x_step),
    .idx          (pix_col),
    .coord        (c_re),
    .at_max       (x_at_max),
    .at_max_nxt_c (x_max_nxt)
  );

  julia_axis_stepper #(
    .W       (COORD_W),
    .IDX_W   (IDX_W),
    .MAX_IDX (V_RES - 1)
  ) u_y_axis (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .step_en      (y_step_en),
    .wrap         (1'b0),
    .base         (y_0),
    .step         (y_step),
    .idx          (pix_row),
    .coord        (c_im),
    .at_max       (y_at_max),
    .at_max_nxt_c (y_max_nxt)
  );

  // Next state and stepper controls; out_ready only reaches registers.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = out_valid & out_ready;
    frame_end = xfer & x_at_max & y_at_max;
    x_step_en = xfer & ~frame_end;
    y_step_en = xfer & x_at_max & ~y_at_max;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (frame_end) state_nxt = DONE;
`ifdef JULIA_CONTINUOUS_FRAME_EN
      DONE: state_nxt = LOAD;
`else
      DONE: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      last       <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_valid  <= (state_nxt == RUN);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      last       <= (state_nxt == RUN) & x_max_nxt & y_max_nxt;
    end
  end

endmodule

// File: tb/tb_julia_coord_gen.sv
// Directed bench for julia_coord_gen on a 4x3 raster with bit-exact coordinate checks.
module tb_julia_coord_gen;

  localparam int unsigned CW = 27;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned IW = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] x_0, x_step, y_0, y_step;
  logic          start;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_re, c_im;
  logic [IW-1:0] pix_col, pix_row;
  logic          last, busy, frame_done;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] cap_re [H*V];
  logic [CW-1:0] cap_im [H*V];
  logic [CW-1:0] exp_row_re [4] = '{27'h7C00000, 27'h7D00000, 27'h7E00000, 27'h7F00000};
  logic [CW-1:0] exp_col_im [3] = '{27'h0400000, 27'h0300000, 27'h0200000};

  julia_coord_gen #(
    .COORD_W (CW),
    .H_RES   (H),
    .V_RES   (V),
    .IDX_W   (IW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x_0        (x_0),
    .x_step     (x_step),
    .y_0        (y_0),
    .y_step     (y_step),
    .start      (start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c_re       (c_re),
    .c_im       (c_im),
    .pix_col    (pix_col),
    .pix_row    (pix_row),
    .last       (last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Closed-form coordinate: base + n*step modulo 2^CW.
  function automatic logic [CW-1:0] lin(input logic [CW-1:0] b, input logic [CW-1:0] s, input int n);
    logic [63:0] p;
    p = 64'(b) + 64'(s) * 64'(n);
    return CW'(p);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
    check({tag, "_last"},  32'(last),      32'd0);
    check({tag, "_re"},    32'(c_re),      32'd0);
    check({tag, "_im"},    32'(c_im),      32'd0);
    check({tag, "_col"},   32'(pix_col),   32'd0);
    check({tag, "_row"},   32'(pix_row),   32'd0);
  endtask

  // Runs one frame; optional stall pattern, mid-frame x_0 change, abort by reset,
  // and start pulses while busy and alongside frame_done.
  task automatic run_frame(input logic [CW-1:0] fx0, input logic [CW-1:0] fxs,
                           input logic [CW-1:0] fy0, input logic [CW-1:0] fys,
                           input bit toggle, input int chg_at, input int abort_at, input bit poke);
    int lat, beats, cyc, col, row;
    x_0 = fx0; x_step = fxs; y_0 = fy0; y_step = fys;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'd2);
    beats = 0;
    cyc   = 0;
    while (beats < int'(H*V) && cyc < 100) begin
      col = beats % int'(H);
      row = beats / int'(H);
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      start     = poke && (cyc == 5);
      check("valid_in_frame", 32'(out_valid), 32'd1);
      if (out_valid) begin
        check("c_re", 32'(c_re), 32'(lin(fx0, fxs, col)));
        check("c_im", 32'(c_im), 32'(lin(fy0, fys, row)));
        check("pix_col", 32'(pix_col), 32'(col));
        check("pix_row", 32'(pix_row), 32'(row));
        check("last", 32'(last), 32'(beats == int'(H*V) - 1));
        if (out_ready) begin
          cap_re[beats] = c_re;
          cap_im[beats] = c_im;
          beats++;
        end
      end
      if (beats == chg_at) x_0 = '0;
      if (beats == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("beat_count", 32'(beats), 32'(H*V));
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("valid_after_last", 32'(out_valid), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("frame_done_single", 32'(frame_done), 32'd0);
    check("busy_after_frame", 32'(busy), 32'd0);
    @(negedge clk);
    check("no_queued_frame", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    x_0 = '0; x_step = '0; y_0 = '0; y_step = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

`ifndef JULIA_CONTINUOUS_FRAME_EN
    run_frame(27'h7C00000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) check("row0_re", 32'(cap_re[i]), 32'(exp_row_re[i]));
    for (int r = 0; r < 3; r++) check("col0_im", 32'(cap_im[r*4]), 32'(exp_col_im[r]));

    run_frame(27'h7C00000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b1, -1, -1, 1'b1);

    run_frame(27'h3FFFFFF, 27'h0000001, 27'h0000000, 27'h0000000, 1'b0, -1, -1, 1'b0);
    check("wrap_re1", 32'(cap_re[1]), 32'h4000000);
    check("wrap_re2", 32'(cap_re[2]), 32'h4000001);

    run_frame(27'h7C00000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b0, 5, -1, 1'b0);
    run_frame(27'h0000000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b0, -1, -1, 1'b0);
    check("new_x0_start", 32'(cap_re[0]), 32'h0000000);

    run_frame(27'h1234567, 27'h0000000, 27'h7654321, 27'h0000000, 1'b0, -1, -1, 1'b0);

    run_frame(27'h7C00000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b0, -1, 7, 1'b0);
    @(negedge clk);
    check_reset_outputs("post_abort");
    run_frame(27'h7C00000, 27'h0100000, 27'h0400000, 27'h7F00000, 1'b0, -1, -1, 1'b0);
`else
    begin
      int last_done, n_done, beats;
      last_done = -1;
      n_done = 0;
      beats = 0;
      x_0 = 27'h7C00000; x_step = 27'h0100000; y_0 = 27'h0400000; y_step = 27'h7F00000;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (frame_done) begin
          if (last_done >= 0) check("done_period", 32'(cyc - last_done), 32'(H*V + 2));
          last_done = cyc;
          n_done++;
        end
        if (out_valid) begin
          check("cont_re", 32'(c_re), 32'(lin(x_0, x_step, beats % int'(H))));
          check("cont_im", 32'(c_im), 32'(lin(y_0, y_step, (beats / int'(H)) % int'(V))));
          beats++;
        end
        @(negedge clk);
      end
      check("done_count_min3", 32'(n_done >= 3), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
